wb_arbiter_2m: RTL and testbench

- Two-master to one-slave Wishbone (pipelined, stall-capable) arbiter for the cached pipelined core.
- Shares the single unified memory slave between the instruction-cache refill port (m0) and the data-cache/uncached data port (m1).
- Round-robin grant, held for the whole bus cycle; outstanding requests tracked and drained before ownership changes.

---
 rtl/wb_arbiter_2m.sv | 177 +++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave pipelined Wishbone arbiter: round-robin grant held for
// the whole bus cycle, with outstanding requests drained before ownership changes.
module wb_arbiter_2m #(
  parameter int WB_AW           = 12,
  parameter int WB_DW           = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int WB_SL          = WB_DW / 8,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // master 0: instruction-cache refill
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [WB_AW-1:0] m0_adr_i,
  input  logic [WB_DW-1:0] m0_dat_i,
  input  logic [WB_SL-1:0] m0_sel_i,
  output logic             m0_stall_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [WB_DW-1:0] m0_dat_o,
  // master 1: data cache / uncached data
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [WB_AW-1:0] m1_adr_i,
  input  logic [WB_DW-1:0] m1_dat_i,
  input  logic [WB_SL-1:0] m1_sel_i,
  output logic             m1_stall_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [WB_DW-1:0] m1_dat_o,
  // shared slave
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [WB_AW-1:0] s_adr_o,
  output logic [WB_DW-1:0] s_dat_o,
  output logic [WB_SL-1:0] s_sel_o,
  input  logic             s_stall_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic [WB_DW-1:0] s_dat_i,
  // observability
  output logic [1:0]       dbg_state_o,
  output logic [CW-1:0]    dbg_count_o
);

  // Handshake: a request is accepted on a cycle where cyc & stb & !stall;
  // every accepted request is answered by exactly one ack or err cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_next;
  logic          cnt_zero;
  logic          cnt_full;
  logic          inc;
  logic          dec;

  assign cnt_zero = (count == '0);
  assign cnt_full = (count == CNT_MAX);

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_err_o   = 1'b0;
    case (state)
      OWN0: begin
        s_cyc_o    = m0_cyc_i | ~cnt_zero;
        s_stb_o    = m0_cyc_i & m0_stb_i & ~cnt_full;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_sel_o    = m0_sel_i;
        m0_stall_o = s_stall_i | cnt_full;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i;
      end
      OWN1: begin
        s_cyc_o    = m1_cyc_i | ~cnt_zero;
        s_stb_o    = m1_cyc_i & m1_stb_i & ~cnt_full;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_sel_o    = m1_sel_i;
        m1_stall_o = s_stall_i | cnt_full;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i;
      end
      // responses to an abandoned cycle are swallowed here
      DRAIN: s_cyc_o = 1'b1;
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // A response arriving with nothing outstanding is a slave fault; the count
  // saturates at zero rather than wrapping.
  assign inc = s_stb_o & ~s_stall_i;
  assign dec = s_ack_i | s_err_i;

  always_comb begin
    cnt_next = count;
    if (inc && !dec)
      cnt_next = count + CW'(1);
    else if (dec && !inc && !cnt_zero)
      cnt_next = count - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
    end else begin
      count <= cnt_next;
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (last_grant) begin
              state      <= OWN0;
              last_grant <= 1'b0;
            end else begin
              state      <= OWN1;
              last_grant <= 1'b1;
            end
          end else if (m0_cyc_i) begin
            state      <= OWN0;
            last_grant <= 1'b0;
          end else if (m1_cyc_i) begin
            state      <= OWN1;
            last_grant <= 1'b1;
          end
        end
        OWN0: begin
          if (!m0_cyc_i)
            state <= (cnt_next == '0) ? IDLE : DRAIN;
        end
        OWN1: begin
          if (!m1_cyc_i)
            state <= (cnt_next == '0) ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (cnt_next == '0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = state;
  assign dbg_count_o = count;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: cycle vector table for arbitration, then a slave model
// with a response scoreboard for bursts, abort/drain, error and mid-burst reset.
module tb_wb_arbiter_2m;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int CW = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_OWN0 = 2'd1, S_OWN1 = 2'd2, S_DRAIN = 2'd3;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [AW-1:0] m0_adr_i = '0;
  logic [DW-1:0] m0_dat_i = '0;
  logic [SL-1:0] m0_sel_i = '1;
  logic m0_stall_o, m0_ack_o, m0_err_o;
  logic [DW-1:0] m0_dat_o;
  logic m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [AW-1:0] m1_adr_i = '0;
  logic [DW-1:0] m1_dat_i = '0;
  logic [SL-1:0] m1_sel_i = '1;
  logic m1_stall_o, m1_ack_o, m1_err_o;
  logic [DW-1:0] m1_dat_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SL-1:0] s_sel_o;
  logic s_stall_i = 0, s_ack_i = 0, s_err_i = 0;
  logic [DW-1:0] s_dat_i = '0;
  logic [1:0] dbg_state_o;
  logic [CW-1:0] dbg_count_o;

  wb_arbiter_2m #(.WB_AW(AW), .WB_DW(DW), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_stall_i(s_stall_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_dat_i(s_dat_i),
    .dbg_state_o(dbg_state_o), .dbg_count_o(dbg_count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // slave model: responses scheduled slv_lat cycles after acceptance
  logic          slv_auto = 1'b0;
  logic          slv_err  = 1'b0;
  int            slv_lat  = 4;
  logic          pv [8];
  logic          pe [8];
  logic [DW-1:0] pd [8];

  // scoreboard: {is_err, read_data} per accepted master request
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic m0_acc, m1_acc;
  int   resp0, resp1;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return 32'h5A00_0000 | {20'h0, a};
  endfunction

  task automatic clear_slave();
    for (int k = 0; k < 8; k++) begin
      pv[k] = 1'b0; pe[k] = 1'b0; pd[k] = '0;
    end
    s_ack_i = 0; s_err_i = 0;
    exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
    m0_acc = 1'b0; m1_acc = 1'b0;
    if (slv_auto) begin
      s_ack_i = pv[0] & ~pe[0];
      s_err_i = pv[0] & pe[0];
      s_dat_i = pd[0];
      for (int k = 0; k < 7; k++) begin
        pv[k] = pv[k+1]; pe[k] = pe[k+1]; pd[k] = pd[k+1];
      end
      pv[7] = 1'b0; pe[7] = 1'b0; pd[7] = '0;
    end
  endtask

  task automatic sample();
    int occ;
    logic [32:0] got;
    #2;
    occ = 0;
    for (int k = 0; k < 8; k++) occ += int'(pv[k]);
    check("count", 64'(dbg_count_o), 64'(occ + int'(s_ack_i | s_err_i)));
    if (m0_cyc_i && m0_stb_i && !m0_stall_o) begin
      m0_acc = 1'b1;
      exp_q0.push_back(slv_err ? {1'b1, 32'h0} : {1'b0, mem_data(m0_adr_i)});
    end
    if (m1_cyc_i && m1_stb_i && !m1_stall_o) begin
      m1_acc = 1'b1;
      exp_q1.push_back(slv_err ? {1'b1, 32'h0} : {1'b0, mem_data(m1_adr_i)});
    end
    if (s_cyc_o && s_stb_o && !s_stall_i) begin
      pv[slv_lat-1] = 1'b1; pe[slv_lat-1] = slv_err; pd[slv_lat-1] = mem_data(s_adr_o);
    end
    if (m0_ack_o || m0_err_o) begin
      resp0++;
      got = m0_err_o ? {1'b1, 32'h0} : {1'b0, m0_dat_o};
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL m0_resp unexpected got=%0h exp=none t=%0t", got, $time);
      end else check("m0_resp", 64'(got), 64'(exp_q0.pop_front()));
    end
    if (m1_ack_o || m1_err_o) begin
      resp1++;
      got = m1_err_o ? {1'b1, 32'h0} : {1'b0, m1_dat_o};
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL m1_resp unexpected got=%0h exp=none t=%0t", got, $time);
      end else check("m1_resp", 64'(got), 64'(exp_q1.pop_front()));
    end
  endtask

  // vector: in={m0_cyc,m0_stb,m1_cyc,m1_stb,s_stall,s_ack}
  //         exp={s_cyc,s_stb,m0_stall,m1_stall,m0_ack,m1_ack,m0_err,m1_err,state}
  typedef struct {
    logic [5:0]    in;
    logic [9:0]    exp;
    logic [AW-1:0] adr;
  } vec_t;
  vec_t vecs[$];

  logic [9:0] obs;
  int ndrain;
  int issued;
  logic saw_full;

  initial begin
    clear_slave();
    resp0 = 0; resp1 = 0;
    m0_adr_i = 12'h100; m1_adr_i = 12'h010;
    #3;
    check("reset_outs", {s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o,
                         m0_err_o, m1_err_o}, 9'b000110000);
    check("reset_state", {dbg_state_o, dbg_count_o}, {S_IDLE, 3'd0});
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;

    vecs.push_back('{6'b001100, 10'b0011000000, 12'h000}); // m1 single read
    vecs.push_back('{6'b001100, 10'b1110000010, 12'h010});
    vecs.push_back('{6'b001001, 10'b1010010010, 12'h000});
    vecs.push_back('{6'b000000, 10'b0010000010, 12'h000});
    vecs.push_back('{6'b111100, 10'b0011000000, 12'h000}); // both: m0 first
    vecs.push_back('{6'b111110, 10'b1111000001, 12'h100});
    vecs.push_back('{6'b111100, 10'b1101000001, 12'h100});
    vecs.push_back('{6'b101101, 10'b1001100001, 12'h000});
    vecs.push_back('{6'b001100, 10'b0001000001, 12'h000});
    vecs.push_back('{6'b001100, 10'b0011000000, 12'h000}); // dead cycle, then m1
    vecs.push_back('{6'b001100, 10'b1110000010, 12'h010});
    vecs.push_back('{6'b001001, 10'b1010010010, 12'h000});
    vecs.push_back('{6'b000000, 10'b0010000010, 12'h000});
    vecs.push_back('{6'b111100, 10'b0011000000, 12'h000}); // both again: m0
    vecs.push_back('{6'b111100, 10'b1101000001, 12'h100});
    vecs.push_back('{6'b001101, 10'b1001100001, 12'h000});
    vecs.push_back('{6'b001100, 10'b0011000000, 12'h000});
    vecs.push_back('{6'b010000, 10'b0010000010, 12'h000}); // stb without cyc
    vecs.push_back('{6'b010000, 10'b0011000000, 12'h000});
    vecs.push_back('{6'b000000, 10'b0011000000, 12'h000});

    s_dat_i = 32'hDEADBEEF;
    foreach (vecs[i]) begin
      next_cycle();
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_stall_i, s_ack_i} = vecs[i].in;
      #2;
      obs = {s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
             dbg_state_o};
      check($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].exp));
      if (vecs[i].exp[8]) check($sformatf("vec%0d_adr", i), 64'(s_adr_o), 64'(vecs[i].adr));
      if (vecs[i].exp[5]) check($sformatf("vec%0d_m0dat", i), 64'(m0_dat_o), 64'hDEADBEEF);
      if (vecs[i].exp[4]) check($sformatf("vec%0d_m1dat", i), 64'(m1_dat_o), 64'hDEADBEEF);
    end
    s_ack_i = 0; s_stall_i = 0;
    slv_auto = 1'b1;

    // burst of 6 reads from m0, slave answers 4 cycles after accept
    slv_lat = 4; issued = 0; saw_full = 0; resp0 = 0;
    for (int c = 0; c < 60 && !(issued == 6 && exp_q0.size() == 0); c++) begin
      next_cycle();
      m0_cyc_i = 1; m0_stb_i = (issued < 6); m0_we_i = 0; m0_sel_i = 4'hF;
      m0_adr_i = 12'h200 + 12'(issued);
      sample();
      if (m0_acc) issued++;
      if (dbg_count_o == 3'd4) begin
        saw_full = 1'b1;
        check("full_stall", {m0_stall_o, s_stb_o}, 2'b10);
      end
    end
    check("burst_resp", resp0, 6);
    check("burst_full_seen", saw_full, 1);
    next_cycle(); m0_cyc_i = 0; m0_stb_i = 0; sample();
    next_cycle(); sample();
    check("burst_end", {dbg_state_o, dbg_count_o}, {S_IDLE, 3'd0});

    // abort: m1 wins (last grant was m0), issues 2, drops cyc; m0 waits
    next_cycle();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 12'h300;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 12'h040;
    sample();
    next_cycle(); sample();
    check("abort_grant", {dbg_state_o, m1_acc}, {S_OWN1, 1'b1});
    next_cycle(); m1_adr_i = 12'h041; sample();
    next_cycle(); m1_cyc_i = 0; m1_stb_i = 0; exp_q1.delete(); sample();
    check("abort_cyc", {s_cyc_o, s_stb_o, dbg_count_o}, {2'b10, 3'd2});
    ndrain = 0;
    for (int c = 0; c < 20; c++) begin
      next_cycle(); sample();
      if (dbg_state_o != S_DRAIN) break;
      ndrain++;
      check("drain_hold", {s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o},
            6'b101100);
    end
    check("drain_len", ndrain, 3);
    check("drain_idle", {dbg_state_o, m0_stall_o}, {S_IDLE, 1'b1});
    next_cycle(); sample();
    check("drain_m0_grant", {dbg_state_o, m0_acc}, {S_OWN0, 1'b1});
    next_cycle(); m0_stb_i = 0; sample();
    for (int c = 0; c < 10 && exp_q0.size() != 0; c++) begin
      next_cycle(); sample();
    end
    check("abort_m0_done", exp_q0.size(), 0);
    next_cycle(); m0_cyc_i = 0; sample();
    next_cycle(); sample();
    check("abort_end", dbg_state_o, S_IDLE);

    // write terminated by err
    slv_lat = 1; slv_err = 1;
    next_cycle();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 12'h0F0;
    m0_dat_i = 32'hAABBCCDD; m0_sel_i = 4'b0101;
    sample();
    next_cycle(); sample();
    check("wr_bus", {s_we_o, s_sel_o, s_dat_o, s_adr_o}, {1'b1, 4'b0101, 32'hAABBCCDD, 12'h0F0});
    check("wr_acc", m0_acc, 1);
    next_cycle(); m0_stb_i = 0; sample();
    check("wr_err", {m0_err_o, m0_ack_o}, 2'b10);
    next_cycle(); m0_cyc_i = 0; m0_we_i = 0; sample();
    check("wr_err_gone", {m0_err_o, m0_ack_o, dbg_count_o}, {2'b00, 3'd0});
    slv_err = 0;
    next_cycle(); sample();

    // async reset with 3 outstanding in OWN1
    slv_lat = 4;
    next_cycle(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 12'h080; sample();
    for (int c = 0; c < 3; c++) begin
      next_cycle(); if (m1_acc || c > 0) m1_adr_i = m1_adr_i + 12'd1; sample();
    end
    next_cycle(); m1_stb_i = 0; sample();
    check("pre_reset", {dbg_state_o, dbg_count_o}, {S_OWN1, 3'd3});
    #1 rst_ni = 0;
    #1;
    check("mid_reset", {s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o, dbg_state_o, dbg_count_o},
          {4'b0011, S_IDLE, 3'd0});
    clear_slave();
    @(posedge clk_i); #1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 12'h0A0; m1_stb_i = 1;
    @(posedge clk_i); #1;
    rst_ni = 1;
    #2;
    check("post_reset_idle", dbg_state_o, S_IDLE);
    next_cycle(); sample();
    check("post_reset_grant", {dbg_state_o, m0_stall_o, m0_acc}, {S_OWN0, 2'b01});
    next_cycle(); m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; sample();
    for (int c = 0; c < 10 && exp_q0.size() != 0; c++) begin
      next_cycle(); sample();
    end
    check("post_reset_resp", exp_q0.size(), 0);
    next_cycle(); m0_cyc_i = 0; sample();
    next_cycle(); sample();
    check("final_idle", {dbg_state_o, dbg_count_o}, {S_IDLE, 3'd0});
    check("final_q1", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
